// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: tracks in-flight predictions in order,
// checks each EX resolution against the oldest one, issues one registered
// table update per resolution and flushes/redirects on a mispredict.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | sweeping o_init_idx over every table entry; fetch held off
// ST_RUN   | normal operation: accept predictions, consume resolutions
// ST_FLUSH | one-cycle bubble after a mispredict; fetch held off
module bp_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fetch_valid,
  input  logic [31:0]                i_fetch_pc,
  input  logic                       i_pred_taken,
  input  logic [31:0]                i_pred_target,
  output logic                       o_fetch_ready,
  input  logic                       i_res_valid,
  input  logic                       i_res_is_branch,
  input  logic                       i_res_is_jump,
  input  logic                       i_res_taken,
  input  logic [31:0]                i_res_target,
  output logic                       o_upd_valid,
  output logic [31:0]                o_upd_pc,
  output logic                       o_upd_taken,
  output logic [31:0]                o_upd_target,
  output logic                       o_upd_is_branch,
  output logic                       o_upd_is_jump,
  output logic                       o_init_valid,
  output logic [IDX_W-1:0]           o_init_idx,
  output logic                       o_flush,
  output logic [31:0]                o_redirect_pc,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [CNT_W-1:0]           o_mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

  state_t state, state_nxt;

  logic [31:0]      q_pc     [DEPTH];
  logic [31:0]      q_target [DEPTH];
  logic [DEPTH-1:0] q_taken;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic        push, pop, mispredict, eff_taken, sweep_done;
  logic [31:0] head_pc, head_target;
  logic        head_taken;

  assign head_pc     = q_pc[rd_ptr];
  assign head_target = q_target[rd_ptr];
  assign head_taken  = q_taken[rd_ptr];
  assign eff_taken   = i_res_taken | i_res_is_jump;
  assign sweep_done  = o_init_valid && (o_init_idx == IDX_LAST);

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // next state, fetch handshake and queue push/pop decisions
  always_comb begin
    state_nxt     = state;
    o_fetch_ready = 1'b0;
    o_busy        = 1'b1;
    push          = 1'b0;
    pop           = 1'b0;
    mispredict    = 1'b0;
    case (state)
      ST_INIT: begin
        if (sweep_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_busy        = 1'b0;
        o_fetch_ready = (o_count < OCC_FULL);
        pop           = i_res_valid && (o_count != '0);
        mispredict    = pop && ((head_taken != eff_taken) ||
                                (eff_taken && (head_target != i_res_target)));
        // a fetch arriving alongside a mispredict is wrong-path and dropped
        push          = i_fetch_valid && o_fetch_ready && !mispredict;
        if (mispredict) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // prediction queue: circular buffer, cleared wholesale on a mispredict
  always_ff @(posedge i_clk) begin
    if (i_rst || mispredict) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]     <= i_fetch_pc;
        q_target[wr_ptr] <= i_pred_target;
        q_taken[wr_ptr]  <= i_pred_taken;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   o_count <= o_count + OCC_W'(1);
        2'b01:   o_count <= o_count - OCC_W'(1);
        default: o_count <= o_count;
      endcase
    end
  end

  // registered update / flush strobes and the saturating mispredict counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_upd_valid      <= 1'b0;
      o_upd_pc         <= '0;
      o_upd_taken      <= 1'b0;
      o_upd_target     <= '0;
      o_upd_is_branch  <= 1'b0;
      o_upd_is_jump    <= 1'b0;
      o_flush          <= 1'b0;
      o_redirect_pc    <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      o_upd_valid     <= pop;
      o_upd_pc        <= pop ? head_pc : '0;
      o_upd_taken     <= pop && eff_taken;
      o_upd_target    <= pop ? i_res_target : '0;
      o_upd_is_branch <= pop && i_res_is_branch;
      o_upd_is_jump   <= pop && i_res_is_jump;
      o_flush         <= mispredict;
      o_redirect_pc   <= mispredict ? (eff_taken ? i_res_target : head_pc + 32'd4) : '0;
      if (mispredict && (o_mispredict_cnt != CNT_MAX))
        o_mispredict_cnt <= o_mispredict_cnt + CNT_W'(1);
    end
  end

  // table-clear sweep: first INIT cycle shows index 0, last shows IDX_LAST
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_init_valid <= 1'b0;
      o_init_idx   <= '0;
    end else if (state == ST_INIT && !sweep_done) begin
      o_init_valid <= 1'b1;
      o_init_idx   <= o_init_valid ? o_init_idx + IDX_W'(1) : '0;
    end else begin
      o_init_valid <= 1'b0;
      o_init_idx   <= '0;
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_bp_update_ctrl;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;
  localparam int NIDX  = 1 << IDX_W;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int CMAX2 = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_fetch_valid, i_pred_taken, i_res_valid, i_res_is_branch, i_res_is_jump, i_res_taken;
  logic [31:0] i_fetch_pc, i_pred_target, i_res_target;

  logic             o_fetch_ready, o_upd_valid, o_upd_taken, o_upd_is_branch, o_upd_is_jump;
  logic             o_init_valid, o_flush, o_busy;
  logic [31:0]      o_upd_pc, o_upd_target, o_redirect_pc;
  logic [IDX_W-1:0] o_init_idx;
  logic [2:0]       o_count;
  logic [CNT_W-1:0] o_mispredict_cnt;

  logic             d2_fetch_ready, d2_upd_valid, d2_upd_taken, d2_upd_is_branch, d2_upd_is_jump;
  logic             d2_init_valid, d2_flush, d2_busy;
  logic [31:0]      d2_upd_pc, d2_upd_target, d2_redirect_pc;
  logic [IDX_W-1:0] d2_init_idx;
  logic [2:0]       d2_count;
  logic [1:0]       d2_mispredict_cnt;

  always #5 i_clk = ~i_clk;

  bp_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_fetch_ready(o_fetch_ready),
    .i_res_valid(i_res_valid), .i_res_is_branch(i_res_is_branch),
    .i_res_is_jump(i_res_is_jump), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_taken(o_upd_taken),
    .o_upd_target(o_upd_target), .o_upd_is_branch(o_upd_is_branch), .o_upd_is_jump(o_upd_is_jump),
    .o_init_valid(o_init_valid), .o_init_idx(o_init_idx),
    .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
    .o_busy(o_busy), .o_count(o_count), .o_mispredict_cnt(o_mispredict_cnt)
  );

  // narrow-counter instance sharing the same stimulus, for saturation
  bp_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_fetch_ready(d2_fetch_ready),
    .i_res_valid(i_res_valid), .i_res_is_branch(i_res_is_branch),
    .i_res_is_jump(i_res_is_jump), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
    .o_upd_valid(d2_upd_valid), .o_upd_pc(d2_upd_pc), .o_upd_taken(d2_upd_taken),
    .o_upd_target(d2_upd_target), .o_upd_is_branch(d2_upd_is_branch), .o_upd_is_jump(d2_upd_is_jump),
    .o_init_valid(d2_init_valid), .o_init_idx(d2_init_idx),
    .o_flush(d2_flush), .o_redirect_pc(d2_redirect_pc),
    .o_busy(d2_busy), .o_count(d2_count), .o_mispredict_cnt(d2_mispredict_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: mode 0=init sweep, 1=run, 2=flush bubble
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t       mq[$];
  int          m_mode = 0;
  int          m_init_cyc = 0;
  int          m_mis = 0;
  logic        e_upd_valid, e_upd_taken, e_br, e_jmp, e_init_valid, e_flush;
  logic [31:0] e_upd_pc, e_upd_target, e_redir, e_init_idx;

  task automatic model_step();
    bit    can_push, eff, mis;
    pred_t h;
    e_upd_valid = 0; e_upd_pc = 0; e_upd_taken = 0; e_upd_target = 0;
    e_br = 0; e_jmp = 0; e_init_valid = 0; e_init_idx = 0; e_flush = 0; e_redir = 0;
    if (i_rst) begin
      m_mode = 0; m_init_cyc = 0; m_mis = 0; mq.delete();
      return;
    end
    case (m_mode)
      0: begin
        m_init_cyc++;
        if (m_init_cyc <= NIDX) begin
          e_init_valid = 1;
          e_init_idx   = m_init_cyc - 1;
        end else m_mode = 1;
      end
      1: begin
        can_push = i_fetch_valid && (mq.size() < DEPTH);
        if (i_res_valid && mq.size() > 0) begin
          h   = mq.pop_front();
          eff = i_res_taken | i_res_is_jump;
          mis = (h.taken != eff) || (eff && (h.target != i_res_target));
          e_upd_valid = 1; e_upd_pc = h.pc; e_upd_taken = eff; e_upd_target = i_res_target;
          e_br = i_res_is_branch; e_jmp = i_res_is_jump;
          if (mis) begin
            m_mis++;
            mq.delete();
            can_push = 0;
            m_mode   = 2;
            e_flush  = 1;
            e_redir  = eff ? i_res_target : h.pc + 32'd4;
          end
        end
        if (can_push) mq.push_back('{pc: i_fetch_pc, taken: i_pred_taken, target: i_pred_target});
      end
      default: m_mode = 1;
    endcase
  endtask

  task automatic compare_all();
    check("fetch_ready", o_fetch_ready, (m_mode == 1) && (mq.size() < DEPTH));
    check("busy", o_busy, m_mode != 1);
    check("count", o_count, mq.size());
    check("upd_valid", o_upd_valid, e_upd_valid);
    check("upd_pc", o_upd_pc, e_upd_pc);
    check("upd_taken", o_upd_taken, e_upd_taken);
    check("upd_target", o_upd_target, e_upd_target);
    check("upd_is_branch", o_upd_is_branch, e_br);
    check("upd_is_jump", o_upd_is_jump, e_jmp);
    check("init_valid", o_init_valid, e_init_valid);
    check("init_idx", o_init_idx, e_init_idx);
    check("flush", o_flush, e_flush);
    check("redirect_pc", o_redirect_pc, e_redir);
    check("mispredict_cnt", o_mispredict_cnt, (m_mis > CMAX) ? CMAX : m_mis);
    check("mispredict_cnt_w2", d2_mispredict_cnt, (m_mis > CMAX2) ? CMAX2 : m_mis);
  endtask

  // inputs are applied at the falling edge; outputs sampled at the next one
  task automatic step();
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic idle();
    i_fetch_valid = 0; i_fetch_pc = 0; i_pred_taken = 0; i_pred_target = 0;
    i_res_valid = 0; i_res_is_branch = 0; i_res_is_jump = 0; i_res_taken = 0; i_res_target = 0;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    i_fetch_valid = 1; i_fetch_pc = pc; i_pred_taken = pt; i_pred_target = tgt;
  endtask

  task automatic set_res(input logic br, input logic jmp, input logic t, input logic [31:0] tgt);
    i_res_valid = 1; i_res_is_branch = br; i_res_is_jump = jmp; i_res_taken = t; i_res_target = tgt;
  endtask

  task automatic run_sweep();
    for (int c = 0; c < NIDX + 1; c++) begin
      idle();
      if (c % 37 == 5) set_res(1, 0, 1, 32'h1234);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    @(negedge i_clk);
    i_rst = 1; step(); step();
    i_rst = 0;

    // init sweep with stray resolutions
    run_sweep();
    check("ready_after_sweep", o_fetch_ready, 1);
    check("busy_after_sweep", o_busy, 0);

    // fill to DEPTH, fifth push refused, drain in order
    for (int k = 0; k < 5; k++) begin
      idle(); set_fetch(32'h100 + 4 * k, 0, 0); step();
    end
    check("full_count", o_count, 4);
    check("full_ready", o_fetch_ready, 0);
    for (int k = 0; k < 4; k++) begin
      idle(); set_res(1, 0, 0, 32'h0); step();
      check("drain_pc", o_upd_pc, 32'h100 + 4 * k);
    end
    idle(); step();
    check("drained_count", o_count, 0);

    // taken with wrong target
    idle(); set_fetch(32'h200, 1, 32'h300); step();
    idle(); set_res(1, 0, 1, 32'h340); step();
    check("tgt_flush", o_flush, 1);
    check("tgt_redirect", o_redirect_pc, 32'h340);
    check("tgt_ready_low", o_fetch_ready, 0);
    idle(); step();
    check("tgt_ready_back", o_fetch_ready, 1);

    // direction mispredict with younger entries and a concurrent push
    idle(); set_fetch(32'h400, 1, 32'h500); step();
    idle(); set_fetch(32'h404, 0, 32'h0); step();
    idle(); set_fetch(32'h408, 0, 32'h0); step();
    idle(); set_res(1, 0, 0, 32'h999); set_fetch(32'h40C, 0, 32'h0); step();
    check("dir_redirect", o_redirect_pc, 32'h404);
    check("dir_count", o_count, 0);
    idle(); step(); step();
    check("dir_push_lost", o_count, 0);

    // resolution on empty queue, then jump with matching target
    idle(); set_res(1, 0, 1, 32'h700); step();
    check("empty_no_upd", o_upd_valid, 0);
    idle(); set_fetch(32'h600, 1, 32'h700); step();
    idle(); set_res(0, 1, 0, 32'h700); step();
    check("jump_taken", o_upd_taken, 1);
    check("jump_no_flush", o_flush, 0);

    // three more mispredicts: 5 total, narrow counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      idle(); set_fetch(32'h800 + 4 * k, 0, 32'h0); step();
      idle(); set_res(1, 0, 1, 32'h900); step();
      idle(); step();
    end
    check("cnt_five", o_mispredict_cnt, 5);
    check("cnt_sat", d2_mispredict_cnt, 3);

    // reset with a non-empty queue
    for (int k = 0; k < 3; k++) begin
      idle(); set_fetch(32'hA00 + 4 * k, 1, 32'hB00); step();
    end
    check("pre_rst_count", o_count, 3);
    idle(); i_rst = 1; step();
    check("rst_count", o_count, 0);
    check("rst_busy", o_busy, 1);
    i_rst = 0; step();
    check("rst_sweep_idx0", o_init_idx, 0);
    for (int c = 0; c < NIDX; c++) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      i_rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 2) != 0)
        set_fetch({$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? 32'h300 : 32'h340);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) set_res(0, 1, 1'($urandom_range(0, 1)),
                                               $urandom_range(0, 1) ? 32'h300 : 32'h340);
        else set_res(1, 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? 32'h300 : 32'h340);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- In-order controller between the fetch-stage branch predictor and the EX-stage branch resolution.
- Keeps a queue of in-flight predictions and compares each resolution against the oldest one.
- Issues exactly one registered predictor-table update per resolved branch or jump, and generates flush/redirect on a mispredict.
- After reset, sequences a table-initialisation sweep before fetch is allowed to proceed.

Parameters:
DEPTH, 4, number of in-flight prediction queue entries (power of 2, ≥2)
IDX_W, 8, predictor table index width; the init sweep covers 2^IDX_W entries
CNT_W, 16, width of the saturating mispredict counter

Ports:
i_clk  in  1  global clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_fetch_valid  in  1  fetch presents a prediction
i_fetch_pc  in  32  PC of the predicted instruction
i_pred_taken  in  1  predicted direction
i_pred_target  in  32  predicted next PC when taken
o_fetch_ready  out  1  prediction accepted this cycle when high with i_fetch_valid
i_res_valid  in  1  EX resolves the oldest in-flight control instruction
i_res_is_branch  in  1  resolved instruction is a conditional branch
i_res_is_jump  in  1  resolved instruction is a jump (always taken)
i_res_taken  in  1  actual direction
i_res_target  in  32  actual target
o_upd_valid  out  1  one-cycle predictor update strobe
o_upd_pc  out  32  PC being updated
o_upd_taken  out  1  actual direction for GHR/PHT/bias update
o_upd_target  out  32  actual target for BTB update
o_upd_is_branch  out  1  update is for a branch
o_upd_is_jump  out  1  update is for a jump
o_init_valid  out  1  init sweep write strobe
o_init_idx  out  IDX_W  table index being cleared
o_flush  out  1  one-cycle pipeline flush
o_redirect_pc  out  32  correct next PC, valid with o_flush
o_busy  out  1  high in INIT or FLUSH
o_count  out  $clog2(DEPTH)+1  queue occupancy
o_mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset values:
  - FSM=INIT, queue empty, o_count=0, sweep index=0, o_mispredict_cnt=0.
  - All o_upd_*, o_flush, o_redirect_pc, o_init_valid, o_init_idx and o_fetch_ready are 0.
  - o_busy=1.
- Reset asserted mid-operation (sweep, flush, non-empty queue):
  - Everything above is restored on the next edge.
  - The sweep restarts at index 0.
- INIT state:
  - From the first cycle after reset deasserts, o_init_valid=1 and o_init_idx counts 0..2^IDX_W-1, one index per cycle.
  - After the last index, the next cycle enters RUN.
  - o_fetch_ready=0 throughout.
  - i_res_valid is ignored: no update, no flush, no count.
- RUN state:
  - o_fetch_ready = (o_count < DEPTH).
  - A push when full is refused even if a pop happens in the same cycle.
  - A push stores {pc, pred_taken, pred_target}.
  - A simultaneous push and pop in a non-full queue leaves o_count unchanged.
  - Pointers wrap modulo DEPTH.
- Resolution in RUN with the queue non-empty:
  - The queue head is popped.
  - Effective taken = i_res_taken | i_res_is_jump.
  - Mispredict = (head.pred_taken != effective taken) OR (effective taken AND head.pred_target != i_res_target).
- Resolution in RUN with the queue empty:
  - Ignored: no pop, no update, no flush.
- Update timing:
  - Latency is 1 cycle: o_upd_* are registered from the resolution inputs and head PC.
  - o_upd_valid is high for exactly the cycle after an accepted resolution.
- Flush on mispredict:
  - o_flush=1 in the same cycle as o_upd_valid.
  - o_redirect_pc = i_res_target if effective taken, else head.pc+4 (32-bit wrap).
  - The whole queue is cleared (younger entries are wrong-path).
  - A fetch push in the resolving cycle is discarded.
  - The FSM enters FLUSH for exactly 1 cycle (o_fetch_ready=0, o_busy=1), then returns to RUN.
- o_mispredict_cnt:
  - Increments by 1 per mispredict.
  - Holds at 2^CNT_W-1.
- Outputs not currently strobed (o_upd_*, o_flush, o_redirect_pc, o_init_*) return to 0 the cycle after their strobe.

Test Plan:
- Reset, release, IDX_W=8 → o_init_idx 0..255 on 256 consecutive cycles, then o_fetch_ready=1 and o_busy=0 on cycle 257; i_res_valid pulsed during the sweep produces no o_upd_valid.
- Push 4 predictions (pc 0x100, 0x104, 0x108, 0x10C, pred_taken=0), then a 5th → 5th refused, o_count=4; resolve 4 not-taken → 4 o_upd_valid pulses with pc in order, no o_flush, o_count=0.
- Push pc 0x200 pred_taken=1 target 0x300, resolve taken target 0x340 → next cycle o_flush=1, o_redirect_pc=0x340, o_upd_target=0x340, o_mispredict_cnt=1, queue empty, o_fetch_ready=0 for one cycle.
- Push pc 0x400 pred_taken=1 target 0x500, resolve not-taken with two younger entries queued and a push in the same cycle → o_redirect_pc=0x404, o_count=0, the concurrent push is lost.
- Resolve with the queue empty in RUN → no o_upd_valid, no o_flush, counters unchanged; jump resolution with i_res_taken=0 against pred_taken=1 and a matching target → no mispredict, o_upd_taken=1.
- Assert i_rst with 3 entries queued and o_mispredict_cnt=5 → the next cycle shows o_count=0, cnt=0, o_busy=1, and the sweep restarts at idx 0; with CNT_W=2, forcing 5 mispredicts leaves cnt=3.
